// File: rtl/kb_pkg.sv
// Shared constants, state encoding and helpers for the PS/2 Set-2 key event decoder.
package kb_pkg;

  localparam logic [7:0] BYTE_00 = 8'h00;
  localparam logic [7:0] BYTE_AA = 8'hAA;
  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_E1 = 8'hE1;
  localparam logic [7:0] BYTE_EE = 8'hEE;
  localparam logic [7:0] BYTE_F0 = 8'hF0;
  localparam logic [7:0] BYTE_FA = 8'hFA;
  localparam logic [7:0] BYTE_FC = 8'hFC;
  localparam logic [7:0] BYTE_FE = 8'hFE;
  localparam logic [7:0] BYTE_FF = 8'hFF;

  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;
  localparam logic [7:0] CODE_CTRL   = 8'h14;
  localparam logic [7:0] CODE_ALT    = 8'h11;

  localparam int ENTRY_W = 10;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_EXT    = 2'd1,
    ST_BRK    = 2'd2,
    ST_EXTBRK = 2'd3
  } state_e;

  // Keyboard responses and self-test bytes that never start a key event.
  function automatic logic isResponse(input logic [7:0] b);
    return (b == BYTE_00) || (b == BYTE_AA) || (b == BYTE_E1) || (b == BYTE_EE) ||
           (b == BYTE_FA) || (b == BYTE_FC) || (b == BYTE_FE) || (b == BYTE_FF);
  endfunction

endpackage

// File: rtl/kb_fifo.sv
// First-word-fall-through synchronous FIFO; head reads zero while empty.
module kb_fifo
  import kb_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int DATA_W = ENTRY_W
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              rd_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wrPtr_q, rdPtr_q;
  logic [ADDR_W:0]   count_q;
  logic              rdOk, wrOk;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (ADDR_W+1)'(DEPTH));
  assign rdOk    = rd_i && !empty_o;
  // A write into a full FIFO is only accepted when a pop frees the slot in the same cycle.
  assign wrOk    = wr_i && (!full_o || rdOk);
  assign dout_o  = empty_o ? '0 : mem_q[rdPtr_q];

  always_ff @(posedge clk_i) begin
    if (wrOk) mem_q[wrPtr_q] <= din_i;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (wrOk) wrPtr_q <= wrPtr_q + 1'b1;
      if (rdOk) rdPtr_q <= rdPtr_q + 1'b1;
      if (wrOk && !rdOk)      count_q <= count_q + 1'b1;
      else if (rdOk && !wrOk) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/kb_code_decoder.sv
// PS/2 Set-2 prefix parser with modifier tracking and an event FIFO.
// Optional typematic repeat suppression is enabled by defining KB_REPEAT_FILTER_EN.
module kb_code_decoder
  import kb_pkg::*;
#(
  parameter int ADDR_W  = 3,
  parameter int TMO_CYC = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scan_code,
  input  logic       scan_done_tick,
  input  logic       rd_key,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_brk,
  output logic       key_empty,
  output logic       key_full,
  output logic       ovf,
  output logic       shift_on,
  output logic       ctrl_on,
  output logic       alt_on
);

  localparam int TMO_W = $clog2(TMO_CYC + 1);

  state_e               state_q, state_d;
  logic [TMO_W-1:0]     tmoCnt_q, tmoCnt_d;
  logic                 evtValid_q, evtValid_d;
  logic [ENTRY_W-1:0]   evt_q, evt_d;
  logic                 shift_q, ctrl_q, alt_q, ovf_q;
  logic                 tmoHit, push, suppress;
  logic                 evtExt, evtBrk;
  logic [7:0]           evtCode;
  logic [ENTRY_W-1:0]   head;

  assign evtExt  = evt_q[9];
  assign evtBrk  = evt_q[8];
  assign evtCode = evt_q[7:0];

  always_comb begin
    state_d    = state_q;
    tmoCnt_d   = '0;
    evtValid_d = 1'b0;
    evt_d      = {2'b00, scan_code};
    tmoHit     = (state_q != ST_WAIT) && (tmoCnt_q == TMO_W'(TMO_CYC - 1));
    // A byte arriving on the timeout cycle still takes precedence.
    if (scan_done_tick) begin
      unique case (state_q)
        ST_WAIT: begin
          if (scan_code == BYTE_E0)       state_d = ST_EXT;
          else if (scan_code == BYTE_F0)  state_d = ST_BRK;
          else if (!isResponse(scan_code)) evtValid_d = 1'b1;
        end
        ST_EXT: begin
          if (scan_code == BYTE_F0) state_d = ST_EXTBRK;
          else if (scan_code != BYTE_E0) begin
            evtValid_d = 1'b1;
            evt_d      = {2'b10, scan_code};
            state_d    = ST_WAIT;
          end
        end
        ST_BRK: begin
          state_d    = ST_WAIT;
          evtValid_d = (scan_code != BYTE_E0) && (scan_code != BYTE_F0);
          evt_d      = {2'b01, scan_code};
        end
        ST_EXTBRK: begin
          state_d    = ST_WAIT;
          evtValid_d = (scan_code != BYTE_E0) && (scan_code != BYTE_F0);
          evt_d      = {2'b11, scan_code};
        end
        default: state_d = ST_WAIT;
      endcase
    end else if (state_q != ST_WAIT) begin
      if (tmoHit) state_d = ST_WAIT;
      else        tmoCnt_d = tmoCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_WAIT;
      tmoCnt_q   <= '0;
      evtValid_q <= 1'b0;
      evt_q      <= '0;
    end else begin
      state_q    <= state_d;
      tmoCnt_q   <= tmoCnt_d;
      evtValid_q <= evtValid_d;
      evt_q      <= evt_d;
    end
  end

`ifdef KB_REPEAT_FILTER_EN
  logic       heldValid_q, heldExt_q;
  logic [7:0] heldCode_q;
  logic       heldMatch;

  assign heldMatch = heldValid_q && (heldExt_q == evtExt) && (heldCode_q == evtCode);
  assign suppress  = evtValid_q && !evtBrk && heldMatch;

  always_ff @(posedge clk) begin
    if (!reset) begin
      heldValid_q <= 1'b0;
      heldExt_q   <= 1'b0;
      heldCode_q  <= '0;
    end else if (evtValid_q) begin
      if (!evtBrk && !heldMatch) begin
        heldValid_q <= 1'b1;
        heldExt_q   <= evtExt;
        heldCode_q  <= evtCode;
      end else if (evtBrk && heldMatch) begin
        heldValid_q <= 1'b0;
      end
    end
  end
`else
  assign suppress = 1'b0;
`endif

  assign push = evtValid_q && !suppress;

  // Modifiers follow every decoded event, even ones the FIFO drops or the filter hides.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_q <= 1'b0;
      ctrl_q  <= 1'b0;
      alt_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (evtValid_q) begin
        if (!evtExt && (evtCode == CODE_LSHIFT || evtCode == CODE_RSHIFT)) shift_q <= !evtBrk;
        if (evtCode == CODE_CTRL) ctrl_q <= !evtBrk;
        if (evtCode == CODE_ALT)  alt_q  <= !evtBrk;
      end
      if (push && key_full && !rd_key) ovf_q <= 1'b1;
    end
  end

  kb_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (ENTRY_W)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .wr_i    (push),
    .din_i   (evt_q),
    .rd_i    (rd_key),
    .dout_o  (head),
    .full_o  (key_full),
    .empty_o (key_empty)
  );

  assign {key_ext, key_brk, key_code} = head;
  assign shift_on = shift_q;
  assign ctrl_on  = ctrl_q;
  assign alt_on   = alt_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_kb_code_decoder.sv
// Directed bench for kb_code_decoder; a short timeout keeps the run brief.
module tb_kb_code_decoder;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       scan_done_tick = 1'b0;
  logic       rd_key = 1'b0;
  logic [7:0] key_code;
  logic       key_ext, key_brk, key_empty, key_full, ovf;
  logic       shift_on, ctrl_on, alt_on;

  int checks = 0;
  int failures = 0;
  logic [9:0] expQ[$];
  logic [7:0] fillCodes [8] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42};

  kb_code_decoder #(.ADDR_W(3), .TMO_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .scan_code(scan_code), .scan_done_tick(scan_done_tick),
    .rd_key(rd_key), .key_code(key_code), .key_ext(key_ext), .key_brk(key_brk),
    .key_empty(key_empty), .key_full(key_full), .ovf(ovf),
    .shift_on(shift_on), .ctrl_on(ctrl_on), .alt_on(alt_on)
  );

  always #5 clk = ~clk;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    scan_code = b;
    scan_done_tick = 1'b1;
    @(posedge clk);
    #1;
    scan_done_tick = 1'b0;
  endtask

  task automatic popKey();
    rd_key = 1'b1;
    @(posedge clk);
    #1;
    rd_key = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkHead(input string tag, input logic [9:0] exp);
    checkOutput(tag, {22'd0, key_ext, key_brk, key_code}, {22'd0, exp});
  endtask

  // Compare and pop every queued expectation in order, then require an empty FIFO.
  task automatic drainCheck(input string tag);
    foreach (expQ[i]) begin
      checkOutput({tag, "_nonempty"}, {31'd0, key_empty}, 32'd0);
      checkHead({tag, "_head"}, expQ[i]);
      popKey();
    end
    checkOutput({tag, "_empty"}, {31'd0, key_empty}, 32'd1);
    expQ.delete();
  endtask

  initial begin
    $display("[TB] start");
    doReset();
    checkOutput("rst_empty", {31'd0, key_empty}, 32'd1);
    checkOutput("rst_full", {31'd0, key_full}, 32'd0);
    checkOutput("rst_ovf", {31'd0, ovf}, 32'd0);
    checkOutput("rst_mods", {29'd0, shift_on, ctrl_on, alt_on}, 32'd0);
    checkHead("rst_head", 10'h000);

    // Single make: empty right after the tick edge, visible one edge later.
    applyStimulus(8'h1C);
    checkOutput("lat_still_empty", {31'd0, key_empty}, 32'd1);
    idle(1);
    checkOutput("lat_nonempty", {31'd0, key_empty}, 32'd0);
    checkHead("lat_head", 10'h01C);
    popKey();
    checkOutput("lat_popped", {31'd0, key_empty}, 32'd1);

    // Break, extended make, extended break.
    applyStimulus(8'hF0); applyStimulus(8'h1C);
    applyStimulus(8'hE0); applyStimulus(8'h75);
    applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h75);
    idle(1);
    expQ = '{10'h11C, 10'h275, 10'h375};
    drainCheck("prefix");

    // Modifiers.
    applyStimulus(8'h12); idle(1);
    checkOutput("shift_make", {31'd0, shift_on}, 32'd1);
    applyStimulus(8'hF0); applyStimulus(8'h12); idle(1);
    checkOutput("shift_break", {31'd0, shift_on}, 32'd0);
    applyStimulus(8'hE0); applyStimulus(8'h12); idle(1);
    checkOutput("fake_shift", {31'd0, shift_on}, 32'd0);
    applyStimulus(8'hE0); applyStimulus(8'h14); idle(1);
    checkOutput("ctrl_ext", {31'd0, ctrl_on}, 32'd1);
    applyStimulus(8'h11); idle(1);
    checkOutput("alt_make", {31'd0, alt_on}, 32'd1);
    applyStimulus(8'hF0); applyStimulus(8'h11); idle(1);
    checkOutput("alt_break", {31'd0, alt_on}, 32'd0);
    applyStimulus(8'hFA); idle(1);
    expQ = '{10'h012, 10'h112, 10'h212, 10'h214, 10'h011, 10'h111};
    drainCheck("mods");

    // Prefix timeout returns to idle without an event.
    applyStimulus(8'hE0);
    idle(TMO + 2);
    checkOutput("tmo_no_event", {31'd0, key_empty}, 32'd1);
    applyStimulus(8'h1C); idle(1);
    expQ = '{10'h01C};
    drainCheck("tmo");

    // Overflow without a read drops the ninth make.
    doReset();
    foreach (fillCodes[i]) applyStimulus(fillCodes[i]);
    idle(1);
    checkOutput("fill_full", {31'd0, key_full}, 32'd1);
    checkOutput("fill_no_ovf", {31'd0, ovf}, 32'd0);
    applyStimulus(8'h4B); idle(1);
    checkOutput("ovf_set", {31'd0, ovf}, 32'd1);
    checkOutput("ovf_full", {31'd0, key_full}, 32'd1);
    foreach (fillCodes[i]) expQ.push_back({2'b00, fillCodes[i]});
    drainCheck("ovf_drop");
    checkOutput("ovf_sticky", {31'd0, ovf}, 32'd1);

    // Overflow with a simultaneous read keeps the ninth make as the tail.
    doReset();
    checkOutput("ovf_cleared", {31'd0, ovf}, 32'd0);
    foreach (fillCodes[i]) applyStimulus(fillCodes[i]);
    applyStimulus(8'h4B);
    popKey();
    checkOutput("rdwr_no_ovf", {31'd0, ovf}, 32'd0);
    checkOutput("rdwr_full", {31'd0, key_full}, 32'd1);
    for (int i = 1; i < 8; i++) expQ.push_back({2'b00, fillCodes[i]});
    expQ.push_back(10'h04B);
    drainCheck("rdwr");

    // Typematic repeats.
    applyStimulus(8'h1C); applyStimulus(8'h1C); applyStimulus(8'h1C);
    applyStimulus(8'hF0); applyStimulus(8'h1C);
    applyStimulus(8'h1C); applyStimulus(8'h1C);
    idle(1);
`ifdef KB_REPEAT_FILTER_EN
    expQ = '{10'h01C, 10'h11C, 10'h01C};
`else
    expQ = '{10'h01C, 10'h01C, 10'h01C, 10'h11C, 10'h01C, 10'h01C};
`endif
    drainCheck("repeat");

    // Reset while an extended break is pending and entries are queued.
    applyStimulus(8'h12); applyStimulus(8'h1C); applyStimulus(8'h14);
    applyStimulus(8'hE0); applyStimulus(8'hF0);
    checkOutput("pre_rst_shift", {31'd0, shift_on}, 32'd1);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    checkOutput("mid_rst_empty", {31'd0, key_empty}, 32'd1);
    checkOutput("mid_rst_ovf", {31'd0, ovf}, 32'd0);
    checkOutput("mid_rst_mods", {29'd0, shift_on, ctrl_on, alt_on}, 32'd0);
    checkHead("mid_rst_head", 10'h000);
    applyStimulus(8'h75); idle(1);
    expQ = '{10'h075};
    drainCheck("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
